// File: rtl/count_chk_pkg.sv
// rtl/count_chk_pkg.sv - shared types, defaults and step helper for the count step checker
package count_chk_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_LOCK_N = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } chk_state_t;

  // Value the counter must present next: one step in the direction of sel, modulo 2^width.
  function automatic logic [31:0] exp_next(input logic [31:0] prev, input logic sel,
                                           input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (sel ? (prev + 32'd1) : (prev - 32'd1)) & mask;
  endfunction

endpackage

// File: rtl/count_step_checker_if.sv
// rtl/count_step_checker_if.sv - observed counter sample bus
interface count_step_checker_if
  import count_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] cnt_in;
  logic             sel_in;

  modport master (output in_valid, output cnt_in, output sel_in);
  modport slave  (input in_valid, input cnt_in, input sel_in);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event tally with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear beats a coincident increment; the tally sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_step_checker.sv
// rtl/count_step_checker.sv - checks every counter step is exactly +1/-1 as the select dictates
module count_step_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic                   clk,
  input  logic                   rstn,
  count_step_checker_if.slave    bus,
  input  logic                   clr,
  output logic                   locked,
  output logic                   dir_up,
  output logic                   err_pulse,
  output logic                   wrap_pulse,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       wrap_count
);

  localparam int GR_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  chk_state_t       state;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_sel;
  logic [GR_W-1:0]  good_run;

  logic step_ok;
  logic wrap_step;
  logic last_good;
  logic err_inc;
  logic wrap_inc;

  // Judge the incoming sample against the reference; prev_sel (not sel_in) sets the direction.
  always_comb begin
    step_ok   = (WIDTH'(exp_next(32'(prev_cnt), prev_sel, WIDTH)) == bus.cnt_in);
    wrap_step = step_ok && (prev_sel ? (prev_cnt == {WIDTH{1'b1}}) : (prev_cnt == '0));
    last_good = (good_run >= GR_W'(LOCK_N - 1));
    err_inc   = (state == LOCKED) && bus.in_valid && !step_ok;
    wrap_inc  = (state == LOCKED) && bus.in_valid && wrap_step;
  end

  // Lock tracking FSM with registered flags; a gap in in_valid drops back to IDLE silently.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      prev_cnt   <= '0;
      prev_sel   <= 1'b0;
      good_run   <= '0;
      locked     <= 1'b0;
      dir_up     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= err_inc;
      wrap_pulse <= wrap_inc;
      if (bus.in_valid) begin
        prev_cnt <= bus.cnt_in;
        prev_sel <= bus.sel_in;
      end
      if ((state != IDLE) && bus.in_valid && step_ok) begin
        dir_up <= prev_sel;
      end
      case (state)
        IDLE: begin
          locked   <= 1'b0;
          good_run <= '0;
          if (bus.in_valid) begin
            state <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!bus.in_valid) begin
            state    <= IDLE;
            good_run <= '0;
            locked   <= 1'b0;
          end else if (step_ok && last_good) begin
            state    <= LOCKED;
            good_run <= '0;
            locked   <= 1'b1;
          end else if (step_ok) begin
            good_run <= good_run + GR_W'(1);
            locked   <= 1'b0;
          end else begin
            good_run <= '0;
            locked   <= 1'b0;
          end
        end
        LOCKED: begin
          good_run <= '0;
          if (!bus.in_valid) begin
            state  <= IDLE;
            locked <= 1'b0;
          end else if (!step_ok) begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          good_run <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_tally (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_wrap_tally (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_count_step_checker.sv
// tb/tb_count_step_checker.sv - directed self-checking bench for count_step_checker
module tb_count_step_checker;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;

  logic       locked0, dir_up0, err_pulse0, wrap_pulse0;
  logic [7:0] err_count0, wrap_count0;
  logic       locked1, dir_up1, err_pulse1, wrap_pulse1;
  logic [7:0] err_count1, wrap_count1;

  int total = 0;
  int bad = 0;

  count_step_checker_if #(.WIDTH(4)) b0 ();
  count_step_checker_if #(.WIDTH(4)) b1 ();

  count_step_checker #(.WIDTH(4), .CNT_W(8), .LOCK_N(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (b0.slave),
    .clr        (clr0),
    .locked     (locked0),
    .dir_up     (dir_up0),
    .err_pulse  (err_pulse0),
    .wrap_pulse (wrap_pulse0),
    .err_count  (err_count0),
    .wrap_count (wrap_count0)
  );

  count_step_checker #(.WIDTH(4), .CNT_W(8), .LOCK_N(1)) dut1 (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (b1.slave),
    .clr        (clr1),
    .locked     (locked1),
    .dir_up     (dir_up1),
    .err_pulse  (err_pulse1),
    .wrap_pulse (wrap_pulse1),
    .err_count  (err_count1),
    .wrap_count (wrap_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] c, input logic s);
    b0.in_valid = v;
    b0.cnt_in   = c;
    b0.sel_in   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [3:0] c, input logic s);
    b1.in_valid = v;
    b1.cnt_in   = c;
    b1.sel_in   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero0(input string tag);
    chk({tag, "_locked"}, 32'(locked0), 0);
    chk({tag, "_dir_up"}, 32'(dir_up0), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse0), 0);
    chk({tag, "_wrap_pulse"}, 32'(wrap_pulse0), 0);
    chk({tag, "_err_count"}, 32'(err_count0), 0);
    chk({tag, "_wrap_count"}, 32'(wrap_count0), 0);
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] c;

    b0.in_valid = 1'b0; b0.cnt_in = 4'd0; b0.sel_in = 1'b0;
    b1.in_valid = 1'b0; b1.cnt_in = 4'd0; b1.sel_in = 1'b0;

    // Reset state
    rstn = 1'b0;
    drive0(1'b0, 4'd0, 1'b0);
    drive0(1'b0, 4'd0, 1'b0);
    chk_all_zero0("reset");
    rstn = 1'b1;

    // Up count 3..15,0..6 with sel=1
    for (int i = 0; i < 20; i++) begin
      v = 4'(3 + i);
      drive0(1'b1, v, 1'b1);
      if (i == 1) chk("lock_after_2", 32'(locked0), 0);
      if (i == 2) chk("lock_after_3", 32'(locked0), 1);
      if (i >= 2) chk($sformatf("up_wrap_%0d", i), 32'(wrap_pulse0), 32'(v == 4'd0));
      if (i >= 1) chk($sformatf("up_err_%0d", i), 32'(err_pulse0), 0);
    end
    chk("up_wrap_count", 32'(wrap_count0), 1);
    chk("up_err_count", 32'(err_count0), 0);
    chk("up_dir", 32'(dir_up0), 1);

    // Turn around to down counting, then 0 -> 15 wrap
    drive0(1'b1, 4'd7, 1'b0);
    chk("turn_dir_still_up", 32'(dir_up0), 1);
    for (int i = 6; i >= 0; i--) begin
      drive0(1'b1, 4'(i), 1'b0);
      chk($sformatf("dn_wrap_%0d", i), 32'(wrap_pulse0), 0);
    end
    chk("dn_dir", 32'(dir_up0), 0);
    drive0(1'b1, 4'd15, 1'b0);
    chk("dn_wrap_pulse", 32'(wrap_pulse0), 1);
    chk("dn_wrap_count", 32'(wrap_count0), 2);
    drive0(1'b1, 4'd14, 1'b0);
    chk("dn_wrap_once", 32'(wrap_pulse0), 0);
    chk("dn_err_count", 32'(err_count0), 0);
    chk("dn_locked", 32'(locked0), 1);

    // Down to 7, turning sel up on the 7 sample, then inject 9
    for (int i = 13; i >= 8; i--) drive0(1'b1, 4'(i), 1'b0);
    drive0(1'b1, 4'd7, 1'b1);
    chk("pre_err_locked", 32'(locked0), 1);
    drive0(1'b1, 4'd9, 1'b1);
    chk("inj_err_pulse", 32'(err_pulse0), 1);
    chk("inj_err_count", 32'(err_count0), 1);
    chk("inj_locked", 32'(locked0), 0);
    drive0(1'b1, 4'd10, 1'b1);
    chk("inj_pulse_one_cycle", 32'(err_pulse0), 0);
    chk("relock_1", 32'(locked0), 0);
    drive0(1'b1, 4'd11, 1'b1);
    chk("relock_2", 32'(locked0), 1);
    chk("relock_err_count", 32'(err_count0), 1);

    // Up through the wrap to 5, then sel toggles: 5,6,5,4 all legal
    for (int i = 12; i <= 21; i++) drive0(1'b1, 4'(i), 1'b1);
    chk("tog_wrap_count", 32'(wrap_count0), 3);
    drive0(1'b1, 4'd6, 1'b0);
    chk("tog_6_err", 32'(err_pulse0), 0);
    chk("tog_6_dir", 32'(dir_up0), 1);
    drive0(1'b1, 4'd5, 1'b0);
    chk("tog_5_err", 32'(err_pulse0), 0);
    chk("tog_5_dir", 32'(dir_up0), 0);
    drive0(1'b1, 4'd4, 1'b0);
    chk("tog_4_locked", 32'(locked0), 1);
    chk("tog_err_count", 32'(err_count0), 1);

    // Reset while locked with nonzero tallies
    rstn = 1'b0;
    clr0 = 1'b0;
    drive0(1'b1, 4'd3, 1'b0);
    chk_all_zero0("midrst");
    rstn = 1'b1;
    drive0(1'b1, 4'd2, 1'b0);
    chk("post_rst_ref_err", 32'(err_pulse0), 0);
    chk("post_rst_ref_wrap", 32'(wrap_pulse0), 0);
    chk("post_rst_ref_locked", 32'(locked0), 0);
    drive0(1'b1, 4'd1, 1'b0);
    chk("post_rst_acq", 32'(locked0), 0);
    drive0(1'b1, 4'd0, 1'b0);
    chk("post_rst_lock", 32'(locked0), 1);

    // Valid gap drops lock without an error
    drive0(1'b0, 4'd0, 1'b0);
    chk("gap_locked", 32'(locked0), 0);
    chk("gap_err", 32'(err_pulse0), 0);
    chk("gap_err_count", 32'(err_count0), 0);

    // Held value is illegal
    drive0(1'b1, 4'd5, 1'b0);
    drive0(1'b1, 4'd4, 1'b0);
    drive0(1'b1, 4'd3, 1'b0);
    chk("hold_pre_locked", 32'(locked0), 1);
    drive0(1'b1, 4'd3, 1'b0);
    chk("hold_err", 32'(err_pulse0), 1);
    chk("hold_err_count", 32'(err_count0), 1);
    chk("hold_locked", 32'(locked0), 0);
    drive0(1'b0, 4'd0, 1'b0);

    // LOCK_N=1 instance: 300 alternating break/relock errors saturate the tally
    c = 4'd0;
    drive1(1'b1, c, 1'b1);
    c = c + 4'd1;
    drive1(1'b1, c, 1'b1);
    chk("sat_locked_first", 32'(locked1), 1);
    for (int k = 0; k < 300; k++) begin
      c = c + 4'd3;
      drive1(1'b1, c, 1'b1);
      if (k == 0) chk("sat_first_err", 32'(err_pulse1), 1);
      if (k == 0) chk("sat_first_count", 32'(err_count1), 1);
      c = c + 4'd1;
      drive1(1'b1, c, 1'b1);
    end
    chk("sat_err_count", 32'(err_count1), 255);
    chk("sat_relocked", 32'(locked1), 1);
    c = c + 4'd3;
    clr1 = 1'b1;
    drive1(1'b1, c, 1'b1);
    clr1 = 1'b0;
    chk("clr_err_pulse", 32'(err_pulse1), 1);
    chk("clr_err_count", 32'(err_count1), 0);
    c = c + 4'd1;
    drive1(1'b1, c, 1'b1);
    c = c + 4'd5;
    drive1(1'b1, c, 1'b1);
    chk("after_clr_err_count", 32'(err_count1), 1);
    drive1(1'b0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
